// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALUOp selects, funct/opcode values, mult/div FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package ex_pkg;

    // ALUOp selects from decode
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OPC   = 2'b11;

    // R-type funct codes
    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    // I-type opcodes decoded when ALUOp selects opcode decode
    localparam logic [5:0] OP_SLTI = 6'h0A;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI = 6'h0E;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) with HI/LO result registers.
// Latency: 1 start cycle + DATA_W step cycles + 1 done cycle; divide by zero skips the steps.
// Backpressure: busy_o is the upstream stall; HI/LO update on the edge leaving DONE.
module muldiv_unit
    import ex_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              is_div_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    md_state_t           state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [DATA_W-1:0]   opb_q, opb_d;     // multiplicand or divisor
    logic [2*DATA_W-1:0] acc_q, acc_d;     // {upper, lower}: {partial product, multiplier} or {remainder, quotient}
    logic                div_q, div_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;

    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_next;
    logic [DATA_W:0]     rem_sh;
    logic [DATA_W-1:0]   rem_sub;
    logic                rem_ge;
    logic [2*DATA_W-1:0] div_next;

    // One iteration of each algorithm, computed from the current accumulator
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next = {mul_sum, acc_q[DATA_W-1:1]};
        rem_sh   = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
        rem_ge   = rem_sh >= {1'b0, opb_q};
        // Result is below the divisor, so the low DATA_W bits are exact
        rem_sub  = rem_sh[DATA_W-1:0] - opb_q;
        div_next = {(rem_ge ? rem_sub : rem_sh[DATA_W-1:0]), acc_q[DATA_W-2:0], rem_ge};
    end

    // FSM next-state, datapath updates and stall/done outputs
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        div_d   = div_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (start_i && !reset) begin
                    busy_o = 1'b1;
                    div_d  = is_div_i;
                    if (is_div_i && (b_i == '0)) begin
                        // Divide by zero: result is ready immediately, same HI/LO layout as a real divide
                        acc_d   = {a_i, {DATA_W{1'b1}}};
                        state_d = MD_DONE;
                    end else begin
                        opb_d   = b_i;
                        acc_d   = {{DATA_W{1'b0}}, a_i};
                        count_d = '0;
                        state_d = MD_BUSY;
                    end
                end
            end
            MD_BUSY: begin
                busy_o  = 1'b1;
                acc_d   = div_q ? div_next : mul_next;
                count_d = count_q + 1'b1;
                if (count_q == LAST_STEP) begin
                    state_d = MD_DONE;
                end
            end
            MD_DONE: begin
                done_o  = 1'b1;
                hi_d    = acc_q[2*DATA_W-1:DATA_W];
                lo_d    = acc_q[DATA_W-1:0];
                state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MD_IDLE;
            count_q <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            div_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            div_q   <= div_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, shifter, branch/jump targets and decision, plus the iterative mult/div unit.
// Latency: combinational except multu/divu (stall 9 cycles, 1 cycle for divide by zero).
// Backpressure: EX_stall holds PC, IF/ID and ID/EX while mult/div is working.
module ex_stage
    import ex_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] EX_read_data1,
    input  logic [DATA_W-1:0] EX_read_data2,
    input  logic [PC_W-1:0]   EX_instruction,
    input  logic [PC_W-1:0]   EX_pcplus4,
    input  logic [1:0]        EX_ALUOp,
    input  logic              EX_ALUSrc,
    input  logic              EX_RegDst,
    input  logic              EX_Branch,
    input  logic              EX_BranchFlip,
    input  logic              EX_Jump,
    output logic [DATA_W-1:0] EX_alu_result,
    output logic [4:0]        EX_write_reg,
    output logic              EX_zero,
    output logic              EX_branch_taken,
    output logic [PC_W-1:0]   EX_branch_target,
    output logic [PC_W-1:0]   EX_jump_target,
    output logic              EX_stall
);

    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [4:0]        shamt;
    logic [15:0]       imm;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic              md_op;
    logic              md_busy;
    logic              md_done;
    logic [DATA_W-1:0] md_hi;
    logic [DATA_W-1:0] md_lo;

    assign opcode = EX_instruction[31:26];
    assign funct  = EX_instruction[5:0];
    assign shamt  = EX_instruction[10:6];
    assign imm    = EX_instruction[15:0];
    assign alu_a  = EX_read_data1;
    assign alu_b  = EX_ALUSrc ? imm[DATA_W-1:0] : EX_read_data2;

    // While the unit sits in DONE the instruction in EX is the one completing, not a new request
    assign md_op  = (EX_ALUOp == ALUOP_FUNCT) && ((funct == F_MULTU) || (funct == F_DIVU));

    muldiv_unit #(
        .DATA_W(DATA_W)
    ) u_muldiv (
        .clk      (clk),
        .reset    (reset),
        .start_i  (md_op && !md_done),
        .is_div_i (funct == F_DIVU),
        .a_i      (alu_a),
        .b_i      (alu_b),
        .busy_o   (md_busy),
        .done_o   (md_done),
        .hi_o     (md_hi),
        .lo_o     (md_lo)
    );

    // ALU operation select; shifts by >= DATA_W fall out of the shift operators naturally
    always_comb begin
        EX_alu_result = '0;
        case (EX_ALUOp)
            ALUOP_ADD: EX_alu_result = alu_a + alu_b;
            ALUOP_SUB: EX_alu_result = alu_a - alu_b;
            ALUOP_FUNCT: begin
                case (funct)
                    F_ADD:  EX_alu_result = alu_a + alu_b;
                    F_SUB:  EX_alu_result = alu_a - alu_b;
                    F_AND:  EX_alu_result = alu_a & alu_b;
                    F_OR:   EX_alu_result = alu_a | alu_b;
                    F_XOR:  EX_alu_result = alu_a ^ alu_b;
                    F_NOR:  EX_alu_result = ~(alu_a | alu_b);
                    F_SLT:  EX_alu_result = {{(DATA_W-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
                    F_SLTU: EX_alu_result = {{(DATA_W-1){1'b0}}, (alu_a < alu_b)};
                    F_SLL:  EX_alu_result = alu_a << shamt;
                    F_SRL:  EX_alu_result = alu_a >> shamt;
                    F_SRA:  EX_alu_result = $signed(alu_a) >>> shamt;
                    F_MFHI: EX_alu_result = md_hi;
                    F_MFLO: EX_alu_result = md_lo;
                    default: EX_alu_result = '0;
                endcase
            end
            ALUOP_OPC: begin
                case (opcode)
                    OP_ANDI: EX_alu_result = alu_a & alu_b;
                    OP_ORI:  EX_alu_result = alu_a | alu_b;
                    OP_XORI: EX_alu_result = alu_a ^ alu_b;
                    OP_SLTI: EX_alu_result = {{(DATA_W-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
                    default: EX_alu_result = alu_a + alu_b;
                endcase
            end
            default: EX_alu_result = '0;
        endcase
    end

    assign EX_zero          = (EX_alu_result == '0);
    assign EX_write_reg     = EX_RegDst ? EX_instruction[15:11] : EX_instruction[20:16];
    assign EX_branch_taken  = EX_Branch & (EX_zero ^ EX_BranchFlip);
    assign EX_branch_target = EX_pcplus4 + {{(PC_W-18){imm[15]}}, imm, 2'b00};
    assign EX_jump_target   = {EX_pcplus4[PC_W-1:PC_W-4], EX_instruction[25:0], 2'b00};
    assign EX_stall         = md_busy;

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rd1, rd2;
    logic [31:0] instr, pc4;
    logic [1:0]  aluop;
    logic        alusrc, regdst, branch, bflip, jump;

    logic [7:0]  res;
    logic [4:0]  wreg;
    logic        zero, taken, stall;
    logic [31:0] btgt, jtgt;

    int total = 0;
    int bad = 0;
    int m_hi = 0;
    int m_lo = 0;
    int stall_cnt = 0;
    bit chk_en = 1'b0;
    bit exp_stall = 1'b0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk              (clk),
        .reset            (reset),
        .EX_read_data1    (rd1),
        .EX_read_data2    (rd2),
        .EX_instruction   (instr),
        .EX_pcplus4       (pc4),
        .EX_ALUOp         (aluop),
        .EX_ALUSrc        (alusrc),
        .EX_RegDst        (regdst),
        .EX_Branch        (branch),
        .EX_BranchFlip    (bflip),
        .EX_Jump          (jump),
        .EX_alu_result    (res),
        .EX_write_reg     (wreg),
        .EX_zero          (zero),
        .EX_branch_taken  (taken),
        .EX_branch_target (btgt),
        .EX_jump_target   (jtgt),
        .EX_stall         (stall)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU from the instruction semantics, using plain integer arithmetic
    function automatic int model_alu(input logic [1:0] op2, input logic [31:0] ins,
                                     input int a, input int b, input int hi, input int lo);
        int sa, sb, sh, f, opc, r;
        sa  = (a >= 128) ? a - 256 : a;
        sb  = (b >= 128) ? b - 256 : b;
        sh  = int'(ins[10:6]);
        f   = int'(ins[5:0]);
        opc = int'(ins[31:26]);
        r   = 0;
        case (op2)
            2'b00: r = a + b;
            2'b01: r = a - b;
            2'b10: begin
                case (f)
                    'h20: r = a + b;
                    'h22: r = a - b;
                    'h24: r = a & b;
                    'h25: r = a | b;
                    'h26: r = a ^ b;
                    'h27: r = ~(a | b);
                    'h2A: r = (sa < sb) ? 1 : 0;
                    'h2B: r = (a < b) ? 1 : 0;
                    'h00: r = a << sh;
                    'h02: r = a >> sh;
                    'h03: r = sa >>> sh;
                    'h10: r = hi;
                    'h12: r = lo;
                    default: r = 0;
                endcase
            end
            default: begin
                case (opc)
                    'h0C: r = a & b;
                    'h0D: r = a | b;
                    'h0E: r = a ^ b;
                    'h0A: r = (sa < sb) ? 1 : 0;
                    default: r = a + b;
                endcase
            end
        endcase
        return r & 255;
    endfunction

    // Per-cycle comparison of every output against the model
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                int b, r, off;
                logic [31:0] bt, jt;
                b   = alusrc ? int'(instr[7:0]) : int'(rd2);
                r   = model_alu(aluop, instr, int'(rd1), b, m_hi, m_lo);
                off = int'($signed(instr[15:0]));
                bt  = pc4 + 32'(off * 4);
                jt  = (pc4 & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) << 2);
                check("alu_result", {24'h0, res}, r);
                check("zero", {31'h0, zero}, (r == 0) ? 1 : 0);
                check("stall", {31'h0, stall}, {31'h0, exp_stall});
                check("branch_taken", {31'h0, taken}, {31'h0, branch & ((r == 0) ^ bflip)});
                check("branch_target", btgt, bt);
                check("jump_target", jtgt, jt);
                if (!(aluop == 2'b10 && (instr[5:0] == 6'h19 || instr[5:0] == 6'h1B)))
                    check("write_reg", {27'h0, wreg}, {27'h0, regdst ? instr[15:11] : instr[20:16]});
                if (stall) stall_cnt++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic r_op(input logic [5:0] f, input logic [7:0] a, input logic [7:0] b, input logic [4:0] sh);
        rd1 = a; rd2 = b;
        instr = {6'h00, 5'd1, 5'd2, 5'd3, sh, f};
        aluop = 2'b10; alusrc = 1'b0; regdst = 1'b1;
        branch = 1'b0; bflip = 1'b0; jump = 1'b0;
    endtask

    task automatic i_op(input logic [5:0] opc, input logic [7:0] a, input logic [15:0] im);
        rd1 = a; rd2 = 8'h5C;
        instr = {opc, 5'd1, 5'd4, im};
        aluop = 2'b11; alusrc = 1'b1; regdst = 1'b0;
        branch = 1'b0; bflip = 1'b0; jump = 1'b0;
    endtask

    // Hold a multu/divu in EX for its full occupancy, then retire it into the model
    task automatic md(input logic div, input logic [7:0] a, input logic [7:0] b);
        int len, prod;
        len = (div && b == 8'h00) ? 2 : 10;
        step();
        r_op(div ? 6'h1B : 6'h19, a, b, 5'd0);
        stall_cnt = 0;
        for (int i = 0; i < len; i++) begin
            exp_stall = (i < len - 1);
            settle();
            if (i < len - 1) step();
        end
        check("stall_cycles", stall_cnt, len - 1);
        exp_stall = 1'b0;
        if (div) begin
            if (b == 8'h00) begin m_lo = 255; m_hi = int'(a); end
            else begin m_lo = int'(a) / int'(b); m_hi = int'(a) % int'(b); end
        end else begin
            prod = int'(a) * int'(b);
            m_hi = prod >> 8;
            m_lo = prod & 255;
        end
    endtask

    initial begin
        reset = 1'b1;
        rd1 = 8'h00; rd2 = 8'h00; instr = 32'h0; pc4 = 32'h0000_0100;
        aluop = 2'b00; alusrc = 1'b0; regdst = 1'b0;
        branch = 1'b0; bflip = 1'b0; jump = 1'b0;
        step();
        step();
        reset = 1'b0;
        chk_en = 1'b1;
        // nop after reset
        settle();
        check("nop_result", {24'h0, res}, 32'h0);
        check("nop_stall", {31'h0, stall}, 32'h0);
        step(); r_op(6'h10, 8'h00, 8'h00, 5'd0); settle();
        check("reset_hi", {24'h0, res}, 32'h0);
        step(); r_op(6'h12, 8'h00, 8'h00, 5'd0); settle();
        check("reset_lo", {24'h0, res}, 32'h0);

        // add / sub via ALUOp 00 / 01
        step(); r_op(6'h00, 8'hF0, 8'h20, 5'd0); aluop = 2'b00; settle();
        check("add_lit", {24'h0, res}, 32'h10);
        check("add_zero", {31'h0, zero}, 32'h0);
        step(); r_op(6'h00, 8'h05, 8'h05, 5'd0); aluop = 2'b01; settle();
        check("sub_lit", {24'h0, res}, 32'h00);
        check("sub_zero", {31'h0, zero}, 32'h1);

        // funct decode
        step(); r_op(6'h24, 8'hF0, 8'h3C, 5'd0); settle(); check("and_lit", {24'h0, res}, 32'h30);
        step(); r_op(6'h25, 8'hF0, 8'h3C, 5'd0); settle();
        step(); r_op(6'h26, 8'hF0, 8'h3C, 5'd0); settle();
        step(); r_op(6'h27, 8'hF0, 8'h0C, 5'd0); settle(); check("nor_lit", {24'h0, res}, 32'h03);
        step(); r_op(6'h2A, 8'hFF, 8'h01, 5'd0); settle(); check("slt_lit", {24'h0, res}, 32'h01);
        step(); r_op(6'h2B, 8'hFF, 8'h01, 5'd0); settle(); check("sltu_lit", {24'h0, res}, 32'h00);
        step(); r_op(6'h03, 8'h80, 8'h11, 5'd9); settle(); check("sra_lit", {24'h0, res}, 32'hFF);
        step(); r_op(6'h02, 8'h80, 8'h11, 5'd9); settle(); check("srl_lit", {24'h0, res}, 32'h00);
        step(); r_op(6'h03, 8'hA0, 8'h11, 5'd2); settle(); check("sra2_lit", {24'h0, res}, 32'hE8);
        step(); r_op(6'h00, 8'h81, 8'h11, 5'd1); settle(); check("sll_lit", {24'h0, res}, 32'h02);
        step(); r_op(6'h00, 8'h81, 8'h11, 5'd8); settle();
        step(); r_op(6'h22, 8'h10, 8'h20, 5'd0); settle();
        step(); r_op(6'h3F, 8'h12, 8'h34, 5'd0); settle(); check("bad_funct", {24'h0, res}, 32'h00);

        // opcode decode
        step(); i_op(6'h0C, 8'hF3, 16'h000F); settle(); check("andi_lit", {24'h0, res}, 32'h03);
        step(); i_op(6'h0D, 8'hF0, 16'h0005); settle();
        step(); i_op(6'h0E, 8'hFF, 16'h000F); settle();
        step(); i_op(6'h0A, 8'h80, 16'h0005); settle(); check("slti_lit", {24'h0, res}, 32'h01);
        step(); i_op(6'h08, 8'hFE, 16'h0003); settle(); check("other_opc_add", {24'h0, res}, 32'h01);

        // multu 0F*11 then mflo, mfhi
        md(1'b0, 8'h0F, 8'h11);
        check("multu_stall_lit", stall_cnt, 9);
        step(); r_op(6'h12, 8'h00, 8'h00, 5'd0); settle(); check("mflo_mul", {24'h0, res}, 32'hFF);
        step(); r_op(6'h10, 8'h00, 8'h00, 5'd0); settle(); check("mfhi_mul", {24'h0, res}, 32'h00);

        // divu C8/07
        md(1'b1, 8'hC8, 8'h07);
        step(); r_op(6'h12, 8'h00, 8'h00, 5'd0); settle(); check("mflo_div", {24'h0, res}, 32'h1C);
        step(); r_op(6'h10, 8'h00, 8'h00, 5'd0); settle(); check("mfhi_div", {24'h0, res}, 32'h04);

        // divu by zero
        md(1'b1, 8'h5A, 8'h00);
        check("div0_stall_lit", stall_cnt, 1);
        step(); r_op(6'h12, 8'h00, 8'h00, 5'd0); settle(); check("mflo_div0", {24'h0, res}, 32'hFF);
        step(); r_op(6'h10, 8'h00, 8'h00, 5'd0); settle(); check("mfhi_div0", {24'h0, res}, 32'h5A);

        // wide product exercising the carry, and a back-to-back divide
        md(1'b0, 8'hFF, 8'hFF);
        step(); r_op(6'h10, 8'h00, 8'h00, 5'd0); settle(); check("mfhi_ffff", {24'h0, res}, 32'hFE);
        md(1'b1, 8'hFF, 8'h10);
        step(); r_op(6'h12, 8'h00, 8'h00, 5'd0); settle(); check("mflo_ff_10", {24'h0, res}, 32'h0F);
        step(); r_op(6'h10, 8'h00, 8'h00, 5'd0); settle();

        // branches and jump
        step(); r_op(6'h00, 8'h03, 8'h04, 5'd0);
        instr = {6'h05, 5'd1, 5'd2, 16'hFFFE}; aluop = 2'b01; regdst = 1'b0;
        branch = 1'b1; bflip = 1'b1; pc4 = 32'h0000_0040; settle();
        check("bne_taken", {31'h0, taken}, 32'h1);
        check("bne_target", btgt, 32'h0000_0038);
        step(); bflip = 1'b0; instr = {6'h04, 5'd1, 5'd2, 16'hFFFE}; settle();
        check("beq_not_taken", {31'h0, taken}, 32'h0);
        step(); rd1 = 8'h07; rd2 = 8'h07; instr = {6'h04, 5'd1, 5'd2, 16'h0010}; settle();
        check("beq_taken", {31'h0, taken}, 32'h1);
        step(); branch = 1'b0; jump = 1'b1; aluop = 2'b00;
        instr = {6'h02, 26'h0123456}; pc4 = 32'hA000_0040; settle();
        check("jump_target_lit", jtgt, 32'hA048_D158);
        step(); jump = 1'b0; pc4 = 32'h0000_0100;

        // reset in the middle of a multiply (at step count 4)
        r_op(6'h19, 8'h0F, 8'h11, 5'd0);
        exp_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            settle();
            step();
        end
        reset = 1'b1;
        settle();
        step();
        reset = 1'b0;
        m_hi = 0; m_lo = 0; exp_stall = 1'b0;
        r_op(6'h12, 8'h00, 8'h00, 5'd0);
        settle();
        check("rst_stall", {31'h0, stall}, 32'h0);
        check("rst_mflo", {24'h0, res}, 32'h00);
        step(); r_op(6'h10, 8'h00, 8'h00, 5'd0); settle();
        check("rst_mfhi", {24'h0, res}, 32'h00);
        step();
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
